// File: rtl/digit_feature_grid_scan_pkg.sv
// Shared types and helpers for the per-character grid feature scanner.
package dfs_pkg;

  localparam int CW_DEF    = 12;
  localparam int CNT_W_DEF = 12;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ARMED,
    ST_DRAIN,
    ST_PUBLISH
  } dfs_state_t;

  // Index width for n entries, never narrower than one bit.
  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/digit_feature_grid_scan_if.sv
// Result port toward the digit classifier: valid/ready plus the feature payload.
interface digit_feature_grid_scan_if #(
  parameter int GR = 3,
  parameter int GC = 3,
  parameter int NH = 2
);
  logic                 o_valid;
  logic                 o_ready;
  logic [GR*GC-1:0]     o_feature;
  logic [NH*GC-1:0]     o_hcross;
  logic [NH:0]          o_vcross;
  logic                 o_box_err;
  logic                 o_overrun;

  modport master (
    output o_valid, o_feature, o_hcross, o_vcross, o_box_err, o_overrun,
    input  o_ready
  );

  modport slave (
    input  o_valid, o_feature, o_hcross, o_vcross, o_box_err, o_overrun,
    output o_ready
  );
endinterface

// File: rtl/digit_feature_grid_scan_div.sv
// Unsigned restoring divider, one quotient bit per cycle; done is a level held until the next start.
module seq_div_u
  import dfs_pkg::*;
#(
  parameter int W = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic [W-1:0] quotient,
  output logic         done
);

  localparam int CNT_W = clog2_min1(W + 1);

  logic [W-1:0]     rem;
  logic [W:0]       trial;
  logic [CNT_W-1:0] steps;

  // quotient doubles as the dividend shift register
  always_comb trial = {rem, quotient[W-1]} - {1'b0, divisor};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem      <= '0;
      quotient <= '0;
      steps    <= '0;
      done     <= 1'b0;
    end else if (start) begin
      rem      <= '0;
      quotient <= dividend;
      steps    <= CNT_W'(W);
      done     <= 1'b0;
    end else if (steps != '0) begin
      steps <= steps - CNT_W'(1);
      if (!trial[W]) begin
        rem      <= trial[W-1:0];
        quotient <= {quotient[W-2:0], 1'b1};
      end else begin
        rem      <= {rem[W-2:0], quotient[W-1]};
        quotient <= {quotient[W-2:0], 1'b0};
      end
      if (steps == CNT_W'(1)) done <= 1'b1;
    end
  end

endmodule

// File: rtl/digit_feature_grid_scan.sv
// Per-frame grid/crossing feature extractor for one segmented plate character.
//   state   | meaning
//   IDLE    | waiting for frame start (i_vs rise)
//   SETUP   | box latched, dividing and accumulating cell boundaries
//   ARMED   | counting stroke pixels until i_vs falls
//   DRAIN   | two cycles to flush the pixel pipeline
//   PUBLISH | copy results to outputs, clear accumulators
module digit_feature_grid_scan
  import dfs_pkg::*;
#(
  parameter int GR    = 3,
  parameter int GC    = 3,
  parameter int NH    = 2,
  parameter int CW    = CW_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_vs,
  input  logic               i_de,
  input  logic [CW-1:0]      i_x,
  input  logic [CW-1:0]      i_y,
  input  logic               i_th,
  input  logic [CW-1:0]      char_up,
  input  logic [CW-1:0]      char_down,
  input  logic [CW-1:0]      char_left,
  input  logic [CW-1:0]      char_right,
  input  logic [NH*CW-1:0]   line_y,
  input  logic [CNT_W-1:0]   thresh,
  digit_feature_grid_scan_if.master res
);

  localparam int NCELL  = GR * GC;
  localparam int MAXG   = (GR > GC) ? GR : GC;
  localparam int COL_W  = clog2_min1(GC);
  localparam int CELL_W = clog2_min1(NCELL);
  localparam int SPAN_W = clog2_min1(NH + 1);
  localparam int TMR_W  = clog2_min1(CW + MAXG + 1);

  dfs_state_t state, state_nx;

  logic              vs_d;
  logic              vs_rise, vs_fall;
  logic [CW-1:0]     up_r, down_r, left_r, right_r;
  logic [CNT_W-1:0]  thresh_r;
  logic [CW-1:0]     line_r [NH];
  logic              box_err_r;
  logic [TMR_W-1:0]  setup_tmr;
  logic              drain_tmr;
  logic [CW-1:0]     colb [GC];
  logic [CW-1:0]     rowb [GR];

  logic [CW-1:0]     w, h, mid_x;
  logic              degen;
  logic              div_start, div_done_c, div_done_r;
  logic [CW-1:0]     qw, qh;
  logic              publish;

  int                col_i, row_i, span_i;
  logic              in_box, hit;
  logic [NH-1:0]     hline;

  logic              s1_hit, s1_mid;
  logic [CELL_W-1:0] s1_cell;
  logic [COL_W-1:0]  s1_col;
  logic [SPAN_W-1:0] s1_span;
  logic [NH-1:0]     s1_hline;

  logic [CNT_W-1:0]  cnt [NCELL];
  logic [NH*GC-1:0]  hcross_r;
  logic [NH:0]       vcross_r;
  logic [NCELL-1:0]  feat;

  logic              valid_q, box_err_q, overrun_q;
  logic [NCELL-1:0]  feature_q;
  logic [NH*GC-1:0]  hcross_q;
  logic [NH:0]       vcross_q;

  assign vs_rise = i_vs & ~vs_d;
  assign vs_fall = ~i_vs & vs_d;

  assign w     = right_r - left_r;
  assign h     = down_r - up_r;
  assign mid_x = left_r + {1'b0, w[CW-1:1]};
  assign degen = (right_r <= left_r) || (down_r <= up_r) ||
                 (w < CW'(GC)) || (h < CW'(GR));

  seq_div_u #(.W(CW)) u_div_col (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (w),
    .divisor  (CW'(GC)),
    .quotient (qw),
    .done     (div_done_c)
  );

  seq_div_u #(.W(CW)) u_div_row (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (div_start),
    .dividend (h),
    .divisor  (CW'(GR)),
    .quotient (qh),
    .done     (div_done_r)
  );

  always_comb begin
    state_nx  = state;
    div_start = 1'b0;
    publish   = 1'b0;
    case (state)
      ST_IDLE:    if (vs_rise) state_nx = ST_SETUP;
      ST_SETUP: begin
        div_start = (setup_tmr == TMR_W'(CW + MAXG));
        if (vs_fall)                           state_nx = ST_IDLE;
        else if (degen || setup_tmr == '0)     state_nx = ST_ARMED;
      end
      ST_ARMED:   if (vs_fall) state_nx = ST_DRAIN;
      ST_DRAIN:   if (drain_tmr == 1'b0) state_nx = ST_PUBLISH;
      ST_PUBLISH: begin
        publish  = 1'b1;
        state_nx = ST_IDLE;
      end
      default:    state_nx = ST_IDLE;
    endcase
  end

  // vs_d resets high so a frame already in progress at reset release is not taken as a new one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      vs_d      <= 1'b1;
      up_r      <= '0;
      down_r    <= '0;
      left_r    <= '0;
      right_r   <= '0;
      thresh_r  <= '0;
      box_err_r <= 1'b0;
      setup_tmr <= '0;
      drain_tmr <= 1'b0;
      for (int k = 0; k < NH; k++) line_r[k] <= '0;
      for (int j = 0; j < GC; j++) colb[j] <= '0;
      for (int j = 0; j < GR; j++) rowb[j] <= '0;
    end else begin
      state <= state_nx;
      vs_d  <= i_vs;
      if (state == ST_IDLE && vs_rise) begin
        up_r      <= char_up;
        down_r    <= char_down;
        left_r    <= char_left;
        right_r   <= char_right;
        thresh_r  <= thresh;
        box_err_r <= 1'b0;
        setup_tmr <= TMR_W'(CW + MAXG);
        colb[0]   <= char_left;
        rowb[0]   <= char_up;
        for (int k = 0; k < NH; k++) line_r[k] <= line_y[k*CW +: CW];
      end
      if (state == ST_SETUP) begin
        if (setup_tmr != '0) setup_tmr <= setup_tmr - TMR_W'(1);
        if (degen) box_err_r <= 1'b1;
        // boundary k lands on the cycle where setup_tmr == MAXG-k, once the quotients are ready
        for (int j = 1; j < GC; j++)
          if (div_done_c && setup_tmr == TMR_W'(MAXG - j)) colb[j] <= colb[j-1] + qw;
        for (int j = 1; j < GR; j++)
          if (div_done_r && setup_tmr == TMR_W'(MAXG - j)) rowb[j] <= rowb[j-1] + qh;
      end
      if (state == ST_ARMED && vs_fall) drain_tmr <= 1'b1;
      else if (state == ST_DRAIN)       drain_tmr <= 1'b0;
    end
  end

  always_comb begin
    col_i  = 0;
    row_i  = 0;
    span_i = 0;
    hline  = '0;
    for (int j = 1; j < GC; j++) if (i_x >= colb[j]) col_i++;
    for (int j = 1; j < GR; j++) if (i_y >= rowb[j]) row_i++;
    for (int k = 0; k < NH; k++) begin
      hline[k] = (i_y == line_r[k]);
      if (line_r[k] >= up_r && line_r[k] <= down_r && line_r[k] <= i_y) span_i++;
    end
    in_box = (i_x >= left_r) && (i_x <= right_r) && (i_y >= up_r) && (i_y <= down_r);
    hit    = (state == ST_ARMED) && i_vs && i_de && i_th && !box_err_r && in_box;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_hit   <= 1'b0;
      s1_mid   <= 1'b0;
      s1_cell  <= '0;
      s1_col   <= '0;
      s1_span  <= '0;
      s1_hline <= '0;
    end else begin
      s1_hit   <= hit;
      s1_mid   <= (i_x == mid_x);
      s1_cell  <= CELL_W'(row_i * GC + col_i);
      s1_col   <= COL_W'(col_i);
      s1_span  <= SPAN_W'(span_i);
      s1_hline <= hline;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NCELL; i++) cnt[i] <= '0;
      hcross_r <= '0;
      vcross_r <= '0;
    end else if (publish) begin
      for (int i = 0; i < NCELL; i++) cnt[i] <= '0;
      hcross_r <= '0;
      vcross_r <= '0;
    end else if (s1_hit) begin
      for (int i = 0; i < NCELL; i++)
        if (s1_cell == CELL_W'(i) && cnt[i] != '1) cnt[i] <= cnt[i] + CNT_W'(1);
      for (int k = 0; k < NH; k++)
        for (int c = 0; c < GC; c++)
          if (s1_hline[k] && s1_col == COL_W'(c)) hcross_r[k*GC + c] <= 1'b1;
      for (int s = 0; s <= NH; s++)
        if (s1_mid && s1_span == SPAN_W'(s)) vcross_r[s] <= 1'b1;
    end
  end

  always_comb begin
    feat = '0;
    for (int i = 0; i < NCELL; i++) feat[i] = (cnt[i] >= thresh_r);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      feature_q <= '0;
      hcross_q  <= '0;
      vcross_q  <= '0;
      box_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (publish) begin
      valid_q   <= 1'b1;
      feature_q <= box_err_r ? '0 : feat;
      hcross_q  <= hcross_r;
      vcross_q  <= vcross_r;
      box_err_q <= box_err_r;
      if (valid_q && !res.o_ready) overrun_q <= 1'b1;
    end else if (valid_q && res.o_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign res.o_valid   = valid_q;
  assign res.o_feature = feature_q;
  assign res.o_hcross  = hcross_q;
  assign res.o_vcross  = vcross_q;
  assign res.o_box_err = box_err_q;
  assign res.o_overrun = overrun_q;

endmodule

// File: tb/tb_digit_feature_grid_scan.sv
// Directed bench: a 3x3/NH=2 scanner and a 4x2/NH=3 scanner with 8-bit counters share one pixel stream.
module tb_digit_feature_grid_scan;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vs, i_de, i_th;
  logic [11:0] i_x, i_y;
  logic [11:0] up, down, left, right;
  logic [23:0] line_a;
  logic [35:0] line_b;
  logic [11:0] thresh_a;
  logic [7:0]  thresh_b;

  int checks = 0;
  int failures = 0;
  int lat;
  bit seen;

  always #5 clk = ~clk;

  digit_feature_grid_scan_if #(.GR(3), .GC(3), .NH(2)) res_a ();
  digit_feature_grid_scan_if #(.GR(4), .GC(2), .NH(3)) res_b ();

  digit_feature_grid_scan #(.GR(3), .GC(3), .NH(2), .CW(12), .CNT_W(12)) dut_a (
    .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y), .i_th(i_th),
    .char_up(up), .char_down(down), .char_left(left), .char_right(right),
    .line_y(line_a), .thresh(thresh_a), .res(res_a)
  );

  digit_feature_grid_scan #(.GR(4), .GC(2), .NH(3), .CW(12), .CNT_W(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .i_vs(i_vs), .i_de(i_de), .i_x(i_x), .i_y(i_y), .i_th(i_th),
    .char_up(up), .char_down(down), .char_left(left), .char_right(right),
    .line_y(line_b), .thresh(thresh_b), .res(res_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic pix(input int mode, input int x, input int y);
    case (mode)
      0:       return 1'b1;
      1:       return (x == 101 && y == 61);
      default: return (x == 122);
    endcase
  endfunction

  // blanking long enough to cover SETUP, then a raster over (100,60)-(145,135)
  task automatic run_frame(input int mode);
    i_vs = 1'b1;
    i_de = 1'b0;
    repeat (30) tick();
    for (int y = 60; y <= 135; y++) begin
      for (int x = 100; x <= 145; x++) begin
        i_x  = 12'(x);
        i_y  = 12'(y);
        i_de = 1'b1;
        i_th = pix(mode, x, y);
        tick();
      end
    end
    i_de = 1'b0;
    i_th = 1'b0;
    repeat (2) tick();
  endtask

  // latency counted in edges after the one that samples the i_vs fall
  task automatic finish_frame(output int l);
    i_vs = 1'b0;
    tick();
    l = 99;
    for (int n = 1; n <= 8; n++) begin
      tick();
      if (res_a.o_valid && l == 99) l = n;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    i_vs = 0; i_de = 0; i_th = 0; i_x = 0; i_y = 0;
    up = 12'd60; down = 12'd135; left = 12'd100; right = 12'd145;
    line_a = {12'd90, 12'd70};
    line_b = {12'd110, 12'd90, 12'd70};
    thresh_a = 12'd50;
    thresh_b = 8'd255;
    res_a.o_ready = 1'b1;
    res_b.o_ready = 1'b1;
    repeat (3) tick();
    chk("rst_valid", res_a.o_valid, 0);
    chk("rst_feature", res_a.o_feature, 0);
    chk("rst_overrun", res_a.o_overrun, 0);
    rst_n = 1'b1;
    tick();

    // full-white box; B's 8-bit counters must saturate to reach 255
    run_frame(0);
    finish_frame(lat);
    chk("white_lat", lat, 3);
    chk("white_feat", res_a.o_feature, 9'h1FF);
    chk("white_hcross", res_a.o_hcross, 6'h3F);
    chk("white_vcross", res_a.o_vcross, 3'h7);
    chk("white_boxerr", res_a.o_box_err, 0);
    chk("b_white_feat", res_b.o_feature, 8'hFF);
    chk("b_white_hcross", res_b.o_hcross, 6'h3F);
    chk("b_white_vcross", res_b.o_vcross, 4'hF);

    thresh_a = 12'd1;
    thresh_b = 8'd1;
    run_frame(1);
    finish_frame(lat);
    chk("dot_lat", lat, 3);
    chk("dot_feat", res_a.o_feature, 9'h001);
    chk("dot_hcross", res_a.o_hcross, 0);
    chk("dot_vcross", res_a.o_vcross, 0);
    chk("b_dot_feat", res_b.o_feature, 8'h01);

    thresh_a = 12'd0;
    run_frame(1);
    finish_frame(lat);
    chk("th0_feat", res_a.o_feature, 9'h1FF);

    thresh_a = 12'd1;
    right = 12'd100;
    run_frame(0);
    finish_frame(lat);
    chk("degen_lat", lat, 3);
    chk("degen_boxerr", res_a.o_box_err, 1);
    chk("degen_feat", res_a.o_feature, 0);
    chk("degen_hcross", res_a.o_hcross, 0);
    chk("degen_vcross", res_a.o_vcross, 0);
    right = 12'd145;

    // i_vs drops while still in SETUP
    i_vs = 1'b1;
    repeat (5) tick();
    i_vs = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      tick();
      if (res_a.o_valid) seen = 1'b1;
    end
    chk("short_nopub", seen, 0);

    res_a.o_ready = 1'b0;
    thresh_a = 12'd50;
    run_frame(0);
    finish_frame(lat);
    chk("hold_lat", lat, 3);
    chk("hold_valid", res_a.o_valid, 1);
    chk("hold_overrun", res_a.o_overrun, 0);
    chk("hold_boxerr", res_a.o_box_err, 0);
    chk("hold_feat", res_a.o_feature, 9'h1FF);
    thresh_a = 12'd1;
    run_frame(1);
    i_vs = 1'b0;
    repeat (6) tick();
    chk("ovr_valid", res_a.o_valid, 1);
    chk("ovr_feat", res_a.o_feature, 9'h001);
    chk("ovr_overrun", res_a.o_overrun, 1);
    res_a.o_ready = 1'b1;
    tick();
    chk("accept_drop", res_a.o_valid, 0);
    chk("accept_sticky", res_a.o_overrun, 1);

    thresh_a = 12'd50;
    i_vs = 1'b1;
    repeat (40) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", res_a.o_valid, 0);
    chk("midrst_feat", res_a.o_feature, 0);
    chk("midrst_overrun", res_a.o_overrun, 0);
    chk("b_midrst_feat", res_b.o_feature, 0);
    i_vs = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    thresh_a = 12'd1;
    run_frame(1);
    finish_frame(lat);
    chk("postrst_lat", lat, 3);
    chk("postrst_feat", res_a.o_feature, 9'h001);

    // vertical stroke on x=122, which is the mid-column for both builds
    thresh_b = 8'd18;
    run_frame(2);
    finish_frame(lat);
    chk("vert_feat", res_a.o_feature, 9'h092);
    chk("vert_hcross", res_a.o_hcross, 6'h12);
    chk("vert_vcross", res_a.o_vcross, 3'h7);
    chk("b_vert_feat", res_b.o_feature, 8'hAA);
    chk("b_vert_hcross", res_b.o_hcross, 6'h2A);
    chk("b_vert_vcross", res_b.o_vcross, 4'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
